// File: rtl/program_memory_pkg.sv
// Shared types and constants for the program memory loader.
package program_memory_pkg;

    typedef enum logic [1:0] {
        LEN  = 2'd0,
        DATA = 2'd1,
        RUN  = 2'd2
    } loader_state_t;

    localparam int HEADER_BYTES = 4;
    localparam int BYTE_WIDTH   = 8;

    // Counter/index width that stays at least one bit for degenerate sizes.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/program_memory_bram.sv
// Simple dual-port RAM: one write port, one synchronous read port whose output
// register holds while rd_en is low and can be cleared synchronously.
module program_memory_bram #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int IDX_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rd_clr,
    input  logic                  wr_en,
    input  logic [IDX_WIDTH-1:0]  wr_idx,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [IDX_WIDTH-1:0]  rd_idx,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_r;

    // Write port; contents are deliberately never reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_idx] <= wr_data;
        end
    end

    // Read port output register with synchronous clear priority.
    always_ff @(posedge clk) begin
        if (rd_clr) begin
            rd_data_r <= '0;
        end else if (rd_en) begin
            rd_data_r <= mem_r[rd_idx];
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/program_memory_loader.sv
// Instruction memory with byte-stream loader (count header + LE words) and a
// one-cycle back-pressured fetch port. Optional check: PROGRAM_MEMORY_FETCH_CHECK_EN.
module program_memory_loader
    import program_memory_pkg::*;
#(
    parameter int ADDR_WIDTH  = 16,
    parameter int WORD_BYTES  = 4,
    parameter int DEPTH_WORDS = 2**(ADDR_WIDTH-2)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            load_valid,
    input  logic [7:0]                      load_byte,
    output logic                            load_ready,
    output logic                            load_done,
    output logic                            load_overflow,
    input  logic                            fetch_req_valid,
    output logic                            fetch_req_ready,
    input  logic [ADDR_WIDTH-1:0]           fetch_addr,
    output logic                            fetch_resp_valid,
    input  logic                            fetch_resp_ready,
    output logic [BYTE_WIDTH*WORD_BYTES-1:0] fetch_resp_data,
    output logic                            fetch_resp_error
);

    localparam int DATA_WIDTH = BYTE_WIDTH * WORD_BYTES;
    localparam int OFF_BITS   = $clog2(WORD_BYTES);
    localparam int CNT_W      = width_of(WORD_BYTES);
    localparam int IDX_W      = width_of(DEPTH_WORDS);
    localparam logic [31:0]      DEPTH_W32 = 32'(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(WORD_BYTES - 1);

    loader_state_t          state_r;
    loader_state_t          state_next_s;
    logic [1:0]             hdr_cnt_r;
    logic [31:0]            len_r;
    logic [31:0]            len_next_s;
    logic [CNT_W-1:0]       byte_cnt_r;
    logic [31:0]            word_cnt_r;
    logic [DATA_WIDTH-1:0]  word_buf_r;
    logic [DATA_WIDTH-1:0]  word_next_s;
    logic                   overflow_r;
    logic                   resp_valid_r;

    logic                   load_ready_s;
    logic                   load_done_s;
    logic                   load_fire_s;
    logic                   hdr_last_s;
    logic                   word_last_byte_s;
    logic                   final_word_s;
    logic                   wr_en_s;
    logic                   req_ready_s;
    logic                   req_fire_s;
    logic                   fetch_err_s;
    logic                   rd_clr_s;
    logic [IDX_W-1:0]       rd_idx_s;
    logic                   unused_addr_s;

    assign load_fire_s      = load_valid && load_ready_s;
    assign hdr_last_s       = (hdr_cnt_r == 2'(HEADER_BYTES - 1));
    assign word_last_byte_s = (byte_cnt_r == LAST_BYTE);
    assign final_word_s     = word_last_byte_s && (word_cnt_r == (len_r - 32'd1));
    assign wr_en_s          = (state_r == DATA) && load_fire_s && word_last_byte_s
                              && (word_cnt_r < DEPTH_W32);

    // Header count with the incoming byte merged at its little-endian position.
    always_comb begin
        len_next_s = len_r;
        len_next_s[BYTE_WIDTH*int'(hdr_cnt_r) +: BYTE_WIDTH] = load_byte;
    end

    // Word being assembled with the incoming byte merged in.
    always_comb begin
        word_next_s = word_buf_r;
        word_next_s[BYTE_WIDTH*int'(byte_cnt_r) +: BYTE_WIDTH] = load_byte;
    end

    // Loader state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= LEN;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Loader next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            LEN: begin
                if (load_fire_s && hdr_last_s) begin
                    state_next_s = (len_next_s == 32'd0) ? RUN : DATA;
                end else begin
                    state_next_s = LEN;
                end
            end
            DATA: begin
                if (load_fire_s && final_word_s) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = DATA;
                end
            end
            RUN:     state_next_s = RUN;
            default: state_next_s = LEN;
        endcase
    end

    // Loader state decode.
    always_comb begin
        load_ready_s = 1'b0;
        load_done_s  = 1'b0;
        case (state_r)
            LEN, DATA: load_ready_s = 1'b1;
            RUN:       load_done_s  = 1'b1;
            default: begin
                load_ready_s = 1'b0;
                load_done_s  = 1'b0;
            end
        endcase
    end

    // Header collection, byte packing and word counting.
    always_ff @(posedge clk) begin
        if (reset) begin
            hdr_cnt_r  <= 2'd0;
            len_r      <= 32'd0;
            byte_cnt_r <= '0;
            word_cnt_r <= 32'd0;
            word_buf_r <= '0;
            overflow_r <= 1'b0;
        end else if (load_fire_s) begin
            case (state_r)
                LEN: begin
                    hdr_cnt_r <= hdr_cnt_r + 2'd1;
                    len_r     <= len_next_s;
                end
                DATA: begin
                    word_buf_r <= word_next_s;
                    if (word_last_byte_s) begin
                        byte_cnt_r <= '0;
                        word_cnt_r <= word_cnt_r + 32'd1;
                        if (word_cnt_r >= DEPTH_W32) begin
                            overflow_r <= 1'b1;
                        end
                    end else begin
                        byte_cnt_r <= byte_cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    hdr_cnt_r <= hdr_cnt_r;
                end
            endcase
        end
    end

    assign req_ready_s = (state_r == RUN) && (!resp_valid_r || fetch_resp_ready);
    assign req_fire_s  = fetch_req_valid && req_ready_s;
    assign rd_idx_s    = fetch_addr[OFF_BITS +: IDX_W];

    // Response valid: set on accept, cleared once the consumer takes it.
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_valid_r <= 1'b0;
        end else if (req_fire_s) begin
            resp_valid_r <= 1'b1;
        end else if (fetch_resp_ready) begin
            resp_valid_r <= 1'b0;
        end
    end

`ifdef PROGRAM_MEMORY_FETCH_CHECK_EN
    logic [ADDR_WIDTH-OFF_BITS-1:0] word_idx_s;
    logic [31:0]                    limit_s;
    logic                           resp_err_r;

    assign word_idx_s  = fetch_addr[ADDR_WIDTH-1:OFF_BITS];
    assign limit_s     = (len_r < DEPTH_W32) ? len_r : DEPTH_W32;
    assign fetch_err_s = ((fetch_addr & ADDR_WIDTH'(WORD_BYTES - 1)) != '0)
                         || (32'(word_idx_s) >= limit_s);

    // Error flag captured alongside the read so both hold under back-pressure.
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_err_r <= 1'b0;
        end else if (req_fire_s) begin
            resp_err_r <= fetch_err_s;
        end
    end

    assign fetch_resp_error = resp_err_r;
`else
    assign fetch_err_s      = 1'b0;
    assign fetch_resp_error = 1'b0;
`endif

    // A failed check clears the read register instead of loading it.
    assign rd_clr_s      = reset || (req_fire_s && fetch_err_s);
    assign unused_addr_s = ^fetch_addr;

    program_memory_bram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH_WORDS),
        .IDX_WIDTH  (IDX_W)
    ) u_bram (
        .clk     (clk),
        .rd_clr  (rd_clr_s),
        .wr_en   (wr_en_s),
        .wr_idx  (word_cnt_r[IDX_W-1:0]),
        .wr_data (word_next_s),
        .rd_en   (req_fire_s),
        .rd_idx  (rd_idx_s),
        .rd_data (fetch_resp_data)
    );

    assign load_ready       = load_ready_s;
    assign load_done        = load_done_s;
    assign load_overflow    = overflow_r;
    assign fetch_req_ready  = req_ready_s;
    assign fetch_resp_valid = resp_valid_r;

endmodule

// File: tb/tb_program_memory_loader.sv
// Scoreboard bench for program_memory_loader: randomized loads and fetches
// checked against a word-array reference model.
module tb_program_memory_loader;

    localparam int AW = 8;
    localparam int WB = 4;
    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          load_valid = 1'b0;
    logic [7:0]    load_byte = 8'h00;
    logic          load_ready;
    logic          load_done;
    logic          load_overflow;
    logic          fetch_req_valid = 1'b0;
    logic          fetch_req_ready;
    logic [AW-1:0] fetch_addr = '0;
    logic          fetch_resp_valid;
    logic          fetch_resp_ready = 1'b1;
    logic [31:0]   fetch_resp_data;
    logic          fetch_resp_error;

    program_memory_loader #(
        .ADDR_WIDTH  (AW),
        .WORD_BYTES  (WB),
        .DEPTH_WORDS (DW)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .load_valid       (load_valid),
        .load_byte        (load_byte),
        .load_ready       (load_ready),
        .load_done        (load_done),
        .load_overflow    (load_overflow),
        .fetch_req_valid  (fetch_req_valid),
        .fetch_req_ready  (fetch_req_ready),
        .fetch_addr       (fetch_addr),
        .fetch_resp_valid (fetch_resp_valid),
        .fetch_resp_ready (fetch_resp_ready),
        .fetch_resp_data  (fetch_resp_data),
        .fetch_resp_error (fetch_resp_error)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] mem_model [DW];
    int unsigned model_n = 0;
    logic [32:0] exp_q [$];
    logic [31:0] words_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected {error, data} for a fetch, from the loaded-program model.
    function automatic logic [32:0] model_fetch(input logic [AW-1:0] a);
        int unsigned idx;
        idx = int'(a) / WB;
`ifdef PROGRAM_MEMORY_FETCH_CHECK_EN
        begin
            int unsigned lim;
            lim = (model_n < DW) ? model_n : DW;
            if ((int'(a) % WB) != 0 || idx >= lim) return {1'b1, 32'h0};
        end
`endif
        return {1'b0, mem_model[idx % DW]};
    endfunction

    // Response monitor and back-pressure stability checks.
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data  = 32'h0;
    logic        prev_err   = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid_held", fetch_resp_valid, 1);
                check("stall_data_held", fetch_resp_data, prev_data);
                check("stall_err_held", fetch_resp_error, prev_err);
            end
            if (fetch_resp_valid && !fetch_resp_ready)
                check("stall_req_ready", fetch_req_ready, 0);
            if (fetch_resp_valid && fetch_resp_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: got data %h with no request outstanding", fetch_resp_data);
                end else begin
                    logic [32:0] e;
                    e = exp_q.pop_front();
                    check("resp_data", fetch_resp_data, e[31:0]);
                    check("resp_error", fetch_resp_error, e[32]);
                end
            end
            prev_stall <= fetch_resp_valid && !fetch_resp_ready;
            prev_data  <= fetch_resp_data;
            prev_err   <= fetch_resp_error;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        load_valid = 1'b1;
        load_byte  = b;
        @(negedge clk);
        check("load_ready", load_ready, 1);
        tick();
        load_valid = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        fetch_req_valid  = 1'b0;
        fetch_resp_ready = 1'b1;
        while ((exp_q.size() != 0 || fetch_resp_valid) && budget < 20) begin
            tick();
            budget++;
        end
        check("drain_outstanding", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        drain();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        check("rst_load_ready", load_ready, 1);
        check("rst_load_done", load_done, 0);
        check("rst_overflow", load_overflow, 0);
        check("rst_req_ready", fetch_req_ready, 0);
        check("rst_resp_valid", fetch_resp_valid, 0);
        check("rst_resp_data", fetch_resp_data, 0);
        check("rst_resp_error", fetch_resp_error, 0);
    endtask

    // Streams header plus words_q[0..n-1], checking overflow after each word.
    task automatic load_program(input int unsigned n, input int gap_max);
        logic [7:0]  bytes_q [$];
        logic [31:0] nn;
        nn = n;
        for (int i = 0; i < 4; i++) bytes_q.push_back(nn[8*i +: 8]);
        for (int w = 0; w < int'(n); w++) begin
            logic [31:0] wd;
            wd = words_q[w];
            for (int i = 0; i < 4; i++) bytes_q.push_back(wd[8*i +: 8]);
        end
        for (int i = 0; i < bytes_q.size(); i++) begin
            if (i == bytes_q.size() - 1) check("done_before_last", load_done, 0);
            send_byte(bytes_q[i]);
            if (i >= 4 && ((i - 4) % 4) == 3)
                check("overflow_after_word", load_overflow, ((i - 4) / 4 >= DW) ? 1 : 0);
            if (i == bytes_q.size() - 1) begin
                check("done_after_last", load_done, 1);
                check("req_ready_after_load", fetch_req_ready, 1);
                check("load_ready_in_run", load_ready, 0);
            end else begin
                repeat ($urandom_range(0, gap_max)) tick();
            end
        end
        for (int w = 0; w < int'(n) && w < DW; w++) mem_model[w] = words_q[w];
        model_n = n;
    endtask

    task automatic fetch(input logic [AW-1:0] a, output int waited);
        waited = 0;
        fetch_req_valid = 1'b1;
        fetch_addr      = a;
        @(negedge clk);
        while (!fetch_req_ready && waited < 50) begin
            tick();
            @(negedge clk);
            waited++;
        end
        if (fetch_req_ready) exp_q.push_back(model_fetch(a));
        else begin
            checks++;
            errors++;
            $display("FAIL fetch_timeout: request to %h never accepted", a);
        end
        tick();
        fetch_req_valid = 1'b0;
    endtask

    task automatic random_fetch_phase(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            fetch_resp_ready = ($urandom_range(0, 3) != 0);
            fetch_req_valid  = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 1) == 1) fetch_addr = AW'($urandom_range(0, 6) * WB);
            else                           fetch_addr = AW'($urandom);
            @(negedge clk);
            if (fetch_req_valid && fetch_req_ready) exp_q.push_back(model_fetch(fetch_addr));
            tick();
        end
        fetch_req_valid  = 1'b0;
        fetch_resp_ready = 1'b1;
    endtask

    initial begin
        int w;
        for (int i = 0; i < DW; i++) mem_model[i] = 32'h0;
        do_reset();

        // Reset in the middle of the header.
        send_byte(8'h03);
        send_byte(8'h00);
        do_reset();

        // Directed three-word program, back-to-back fetches.
        words_q = '{32'h11223344, 32'h55667788, 32'h99AABBCC};
        load_program(3, 0);
        fetch(8'd0, w); check("b2b_wait0", w, 0);
        fetch(8'd4, w); check("b2b_wait1", w, 0);
        fetch(8'd8, w); check("b2b_wait2", w, 0);
        drain();

        // Back-pressure on the response to address 4.
        fetch_resp_ready = 1'b0;
        fetch(8'd4, w);
        repeat (3) begin
            check("bp_data", fetch_resp_data, 32'h55667788);
            tick();
        end
        fetch_resp_ready = 1'b1;
        tick();
        check("bp_valid_drop", fetch_resp_valid, 0);

        // Misaligned fetch.
        fetch(8'd2, w);
        drain();

        // Empty program.
        do_reset();
        words_q = {};
        load_program(0, 0);
        fetch(8'd0, w);
        drain();

        // Overflow: six words into a four-word memory.
        do_reset();
        words_q = {};
        for (int i = 0; i < 6; i++) words_q.push_back($urandom);
        load_program(6, 0);
        for (int a = 0; a <= 16; a += 4) fetch(AW'(a), w);
        drain();
        check("overflow_sticky", load_overflow, 1);

        // Randomized loads and fetch traffic.
        for (int r = 0; r < 6; r++) begin
            int unsigned n;
            do_reset();
            n = $urandom_range(0, 6);
            words_q = {};
            for (int i = 0; i < int'(n); i++) words_q.push_back($urandom);
            load_program(n, 2);
            random_fetch_phase(80);
            drain();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
